mult_dot_accumulator: RTL

MULT_DOT_ACCUMULATOR -- requirements
Module: mult_dot_accumulator

---
 rtl/mult_dot_accumulator_if.sv | 31 +++
 rtl/mult_dot_accumulator.sv | 103 ++++++++++
 2 files changed

// File: rtl/mult_dot_accumulator_if.sv
// Bundle of the product-input, result-handshake and status signals of the dot-product accumulator.
// slave is the accumulator side; master is the producer/consumer side.
interface mult_dot_accumulator_if #(
    parameter int WIDTH      = 8,
    parameter int LENGTH     = 4,
    parameter int ACC_WIDTH  = 20,
    parameter int FIFO_DEPTH = 4
);
    localparam int IDX_W = $clog2(LENGTH);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic [2*WIDTH-1:0]   p_in;
    logic                 p_valid;
    logic                 clear;
    logic [ACC_WIDTH-1:0] sum_out;
    logic                 sum_valid;
    logic                 sum_ready;
    logic [IDX_W-1:0]     index;
    logic [LVL_W-1:0]     fifo_level;
    logic                 overflow;

    modport slave (
        input  p_in, p_valid, clear, sum_ready,
        output sum_out, sum_valid, index, fifo_level, overflow
    );

    modport master (
        output p_in, p_valid, clear, sum_ready,
        input  sum_out, sum_valid, index, fifo_level, overflow
    );
endinterface

// File: rtl/mult_dot_accumulator.sv
// Sums LENGTH products per group into a result FIFO; the sum is visible one cycle after the last product.
// The product stream cannot stall, so a sum arriving at a full FIFO with no pop is dropped and overflow sticks.
module mult_dot_accumulator #(
    parameter int WIDTH      = 8,
    parameter int LENGTH     = 4,
    parameter int ACC_WIDTH  = 20,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    mult_dot_accumulator_if.slave  bus
);
    localparam int IDX_W = $clog2(LENGTH);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [ACC_WIDTH-1:0] acc;
    logic [ACC_WIDTH-1:0] p_ext;
    logic [ACC_WIDTH-1:0] sum_next;
    logic [IDX_W-1:0]     idx;

    logic [ACC_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [LVL_W-1:0]     level;
    logic                 ovf;

    logic last;
    logic empty;
    logic full;
    logic pop;
    logic push;

    assign p_ext    = ACC_WIDTH'(bus.p_in);
    assign sum_next = acc + p_ext;
    assign last     = bus.p_valid && !bus.clear && (idx == IDX_W'(LENGTH - 1));
    assign empty    = (level == LVL_W'(0));
    assign full     = (level == LVL_W'(FIFO_DEPTH));
    assign pop      = !empty && bus.sum_ready;
    // A full FIFO still accepts the new sum when the head leaves in the same cycle.
    assign push     = last && (!full || pop);

    always_ff @(posedge clock) begin
        if (reset) begin
            acc <= '0;
            idx <= '0;
        end else if (bus.clear) begin
            // A product arriving with clear becomes the first element of a fresh group.
            if (bus.p_valid) begin
                acc <= p_ext;
                idx <= IDX_W'(1);
            end else begin
                idx <= IDX_W'(0);
            end
        end else if (bus.p_valid) begin
            if (idx == IDX_W'(LENGTH - 1)) begin
                idx <= IDX_W'(0);
            end else if (idx == IDX_W'(0)) begin
                acc <= p_ext;
                idx <= IDX_W'(1);
            end else begin
                acc <= sum_next;
                idx <= idx + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= sum_next;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
            if (last && full && !pop) begin
                ovf <= 1'b1;
            end
        end
    end

    assign bus.sum_out    = empty ? '0 : mem[rd_ptr];
    assign bus.sum_valid  = !empty;
    assign bus.index      = idx;
    assign bus.fifo_level = level;
    assign bus.overflow   = ovf;
endmodule
